// File: rtl/f32_pkg.sv
// Shared definitions for the sequential binary32 multiplier: field layout,
// constants and FSM state encoding.
package f32_pkg;

  localparam int          SIGN_W   = 1;
  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } f32_state_t;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } f32_t;

endpackage

// File: rtl/mant_mult24.sv
// Iterative 24x24 unsigned shift-add multiplier: one multiplier bit per
// cycle, LSB first, exactly 24 cycles after a load.
module mant_mult24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] op_a,
  input  logic [23:0] op_b,
  output logic [47:0] product,
  output logic        busy
);

  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] acc;
  logic [4:0]  count;

  // count holds the number of iterations still to run
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {24'b0, op_a};
      mplier <= op_b;
      acc    <= '0;
      count  <= 5'd24;
    end else if (count != 5'd0) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 5'd1;
    end
  end

  assign product = acc;
  assign busy    = (count != 5'd0);

endmodule

// File: rtl/fp32_mult.sv
// Sequential IEEE-754 binary32 multiplier with start/done handshake,
// round-to-nearest-even, flush-to-zero on denormals and underflow.
module fp32_mult
  import f32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        done,
  output logic [31:0] p
);

  f32_state_t state, state_next;

  f32_t a_reg, b_reg;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic [23:0] mant_a, mant_b;
  logic signed [9:0] exp_sum;
  logic        res_sign;
  logic        special;
  logic [31:0] special_val;

  logic        sign_r;
  logic signed [9:0] exp_r;
  logic        special_r;
  logic [31:0] special_val_r;
  logic [4:0]  mult_cnt;
  logic [23:0] sig_r;
  logic        g_r, r_r, s_r;
  logic [31:0] res_r;

  logic [47:0] prod;
  logic        mult_busy;
  logic        mult_load;

  logic        round_up;
  logic [24:0] rounded;
  logic signed [9:0] exp_fin;
  logic [22:0] frac_fin;
  logic [31:0] packed_res;

  assign a_zero = (a_reg.exp == 8'h00);
  assign b_zero = (b_reg.exp == 8'h00);
  assign a_inf  = (a_reg.exp == 8'hFF) && (a_reg.frac == '0);
  assign b_inf  = (b_reg.exp == 8'hFF) && (b_reg.frac == '0);
  assign a_nan  = (a_reg.exp == 8'hFF) && (a_reg.frac != '0);
  assign b_nan  = (b_reg.exp == 8'hFF) && (b_reg.frac != '0);

  assign mant_a   = {1'b1, a_reg.frac};
  assign mant_b   = {1'b1, b_reg.frac};
  assign res_sign = a_reg.sign ^ b_reg.sign;
  assign exp_sum  = $signed({2'b00, a_reg.exp}) + $signed({2'b00, b_reg.exp})
                  - $signed(10'(EXP_BIAS));

  // Denormal inputs count as zero, so any exponent of 0 lands in the zero case
  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      special     = 1'b1;
      special_val = QNAN;
    end else if (a_inf || b_inf) begin
      special     = 1'b1;
      special_val = {res_sign, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      special     = 1'b1;
      special_val = {res_sign, 31'b0};
    end
  end

  assign mult_load = (state == S_UNPACK);

  mant_mult24 u_mant_mult24 (
    .clk     (clk),
    .rst     (rst),
    .load    (mult_load),
    .op_a    (mant_a),
    .op_b    (mant_b),
    .product (prod),
    .busy    (mult_busy)
  );

  assign round_up = g_r & (r_r | s_r | sig_r[0]);
  assign rounded  = {1'b0, sig_r} + {24'b0, round_up};
  assign exp_fin  = exp_r + $signed({9'b0, rounded[24]});
  assign frac_fin = rounded[24] ? rounded[23:1] : rounded[22:0];

  always_comb begin
    packed_res = {sign_r, exp_fin[7:0], frac_fin};
    if (exp_fin >= 10'sd255) begin
      packed_res = {sign_r, 8'hFF, 23'b0};
    end else if (exp_fin <= 10'sd0) begin
      packed_res = {sign_r, 31'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The mult counter paces MULT; losing busy early is treated as finished too
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_UNPACK;
      S_UNPACK: state_next = S_MULT;
      S_MULT:   if (mult_cnt == 5'd23 || !mult_busy) state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      special_r     <= 1'b0;
      special_val_r <= '0;
      mult_cnt      <= '0;
      sig_r         <= '0;
      g_r           <= 1'b0;
      r_r           <= 1'b0;
      s_r           <= 1'b0;
      res_r         <= '0;
      p             <= '0;
      done          <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        S_UNPACK: begin
          sign_r        <= res_sign;
          exp_r         <= exp_sum;
          special_r     <= special;
          special_val_r <= special_val;
          mult_cnt      <= '0;
        end
        S_MULT: begin
          mult_cnt <= mult_cnt + 5'd1;
        end
        S_NORM: begin
          if (prod[47]) begin
            sig_r <= prod[47:24];
            g_r   <= prod[23];
            r_r   <= prod[22];
            s_r   <= |prod[21:0];
            exp_r <= exp_r + 10'sd1;
          end else begin
            sig_r <= prod[46:23];
            g_r   <= prod[22];
            r_r   <= prod[21];
            s_r   <= |prod[20:0];
          end
        end
        S_ROUND: begin
          res_r <= special_r ? special_val_r : packed_res;
        end
        S_DONE: begin
          p <= res_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mult.sv
// Scoreboard bench for fp32_mult: expected products are queued when a
// request is issued and compared whenever the DUT pulses done.
module tb_fp32_mult;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        done;
  logic [31:0] p;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  fp32_mult dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .start (start),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued result
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        checkOutput(t, p, e);
      end
    end
  end

  // Issues one request; glitch>0 injects an ignored start that many edges in
  task automatic applyStimulus(input string tag, input logic [31:0] op_a,
                               input logic [31:0] op_b, input logic [31:0] want,
                               input int glitch);
    int lat;
    lat = 0;
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (glitch > 0 && i == glitch) begin
        a     = 32'h40400000;
        b     = 32'h40400000;
        start = 1'b1;
      end else if (glitch > 0 && i == glitch + 1) begin
        start = 1'b0;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd28);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    checkOutput(tag, 32'(cnt), 32'd0);
  endtask

  task automatic resetDuringMult();
    @(negedge clk);
    a     = 32'h3F800000;
    b     = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    watchNoDone("rst_no_done", 40);
    checkOutput("rst_p", p, 32'h0);
  endtask

  initial begin
    rst   = 1'b1;
    a     = 32'h0;
    b     = 32'h0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_p", p, 32'h0);

    applyStimulus("mul_2p5_7",      32'h40200000, 32'h40E00000, 32'h418C0000, 0);
    @(negedge clk);
    applyStimulus("mul_15_33",      32'h41720000, 32'h42044000, 32'h43FA0900, 0);
    applyStimulus("inf_x_zero",     32'h7F800000, 32'h00000000, 32'h7FC00000, 0);
    applyStimulus("ninf_x_2",       32'hFF800000, 32'h40000000, 32'hFF800000, 0);
    applyStimulus("nzero_x_1",      32'h80000000, 32'h3F800000, 32'h80000000, 0);
    applyStimulus("overflow",       32'h7F000000, 32'h7F000000, 32'h7F800000, 0);
    applyStimulus("underflow",      32'h00800000, 32'h00800000, 32'h00000000, 0);
    applyStimulus("round_near",     32'h3F800001, 32'h3F800001, 32'h3F800002, 0);
    applyStimulus("tie_to_even_up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0);
    applyStimulus("tie_to_even_dn", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 0);
    applyStimulus("norm_shift",     32'h3FC00000, 32'h3FC00000, 32'h40100000, 0);
    applyStimulus("neg_x_pos",      32'hC0000000, 32'h40400000, 32'hC0C00000, 0);
    applyStimulus("nan_in",         32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0);
    applyStimulus("inf_x_inf",      32'h7F800000, 32'h7F800000, 32'h7F800000, 0);
    applyStimulus("denorm_zero",    32'h00400000, 32'h40000000, 32'h00000000, 0);

    applyStimulus("mid_start",      32'h40000000, 32'h40A00000, 32'h41200000, 5);
    watchNoDone("mid_start_ignored", 40);

    resetDuringMult();
    applyStimulus("after_rst",      32'h40400000, 32'h40800000, 32'h41400000, 0);

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
